// File: rtl/led_fade_pwm_if.sv
// Control and LED-drive signals between the upstream LED sources and the PWM fade stage.
interface led_fade_pwm_if #(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned PWM_BITS = 8
) ();
    logic                en;
    logic [N_LED-1:0]    led_in;
    logic [PWM_BITS-1:0] max_level;
    logic [N_LED-1:0]    led_out;
    logic                period_strobe;
    logic                busy;

    modport master (
        output en,
        output led_in,
        output max_level,
        input  led_out,
        input  period_strobe,
        input  busy
    );

    modport slave (
        input  en,
        input  led_in,
        input  max_level,
        output led_out,
        output period_strobe,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// PWM LED driver that fades each channel's duty toward an on/off target under a brightness
// ceiling; holds all state while disabled and blanks the pins.
module led_fade_pwm #(
    parameter int unsigned N_LED        = 8,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned FADE_PERIODS = 4,
    parameter int unsigned STEP         = 16
) (
    input logic            clk,
    input logic            rst,
    led_fade_pwm_if.slave  bus
);

    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FCNT_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [FCNT_W-1:0]   FCNT_MAX = FCNT_W'(FADE_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS + 1)'(STEP);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [PWM_BITS-1:0] duty_q [N_LED];
    logic [PWM_BITS-1:0] duty_d [N_LED];
    logic [N_LED-1:0]    led_q, led_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;

    logic tick, wrap, fade_step;

    always_comb begin
        tick      = bus.en && (pre_q == PRE_MAX);
        wrap      = tick && (pwm_q == PWM_MAX);
        fade_step = wrap && (fcnt_q == FCNT_MAX);

        pre_d = pre_q;
        if (bus.en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        pwm_d = tick ? pwm_q + 1'b1 : pwm_q;

        fcnt_d = fcnt_q;
        if (wrap) begin
            fcnt_d = (fcnt_q == FCNT_MAX) ? '0 : fcnt_q + 1'b1;
        end

        strobe_d = wrap;
    end

    // Fade math is done one bit wider so the step can never wrap past the target.
    always_comb begin
        logic [PWM_BITS-1:0] target;
        logic [PWM_BITS:0]   duty_x;
        logic [PWM_BITS:0]   tgt_x;
        logic [PWM_BITS:0]   up_x;

        target = '0;
        duty_x = '0;
        tgt_x  = '0;
        up_x   = '0;
        busy_d = 1'b0;
        led_d  = '0;

        for (int i = 0; i < N_LED; i++) begin
            target = bus.led_in[i] ? bus.max_level : '0;
            duty_x = {1'b0, duty_q[i]};
            tgt_x  = {1'b0, target};
            up_x   = duty_x + STEP_X;

            duty_d[i] = duty_q[i];
            if (fade_step) begin
                if (duty_x < tgt_x) begin
                    duty_d[i] = (up_x > tgt_x) ? target : up_x[PWM_BITS-1:0];
                end else if (duty_x > tgt_x) begin
                    duty_d[i] = ((duty_x - tgt_x) > STEP_X) ?
                                duty_q[i] - STEP_X[PWM_BITS-1:0] : target;
                end
            end

            busy_d   = busy_d | (duty_q[i] != target);
            led_d[i] = bus.en && (duty_q[i] > pwm_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            pwm_q    <= '0;
            fcnt_q   <= '0;
            led_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            pwm_q    <= pwm_d;
            fcnt_q   <= fcnt_d;
            led_q    <= led_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            for (int i = 0; i < N_LED; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign bus.led_out       = led_q;
    assign bus.period_strobe = strobe_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: reset timing, fade up, ceiling drop, glitch rejection,
// enable freeze and reset mid-fade, judged from per-period LED on-time counts.
module tb_led_fade_pwm;

    localparam int unsigned N_LED    = 8;
    localparam int unsigned PWM_BITS = 8;
    localparam int          PERIOD   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_fade_pwm_if #(.N_LED(N_LED), .PWM_BITS(PWM_BITS)) bus ();

    led_fade_pwm #(
        .N_LED       (N_LED),
        .PWM_BITS    (PWM_BITS),
        .PRESCALE    (4),
        .FADE_PERIODS(1),
        .STEP        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int   hi_cnt [N_LED];
    logic busy_first;
    logic strobe_end;
    int   early_strobe;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Call at the negedge where period_strobe was just seen; samples the next full period.
    task automatic measure_period();
        for (int i = 0; i < N_LED; i++) hi_cnt[i] = 0;
        early_strobe = 0;
        for (int s = 1; s <= PERIOD; s++) begin
            @(negedge clk);
            if (s == 1) busy_first = bus.busy;
            if (s < PERIOD && bus.period_strobe) early_strobe++;
            for (int i = 0; i < N_LED; i++) hi_cnt[i] += int'(bus.led_out[i]);
        end
        strobe_end = bus.period_strobe;
    endtask

    task automatic check_period(input string tag, input int exp0, input int exp_other,
                                input int exp_busy);
        int other;
        measure_period();
        other = 0;
        for (int i = 1; i < N_LED; i++) other += hi_cnt[i];
        check_val({tag, "_led0"}, hi_cnt[0], exp0);
        check_val({tag, "_other"}, other, exp_other);
        check_val({tag, "_busy"}, int'(busy_first), exp_busy);
        check_val({tag, "_strobe"}, int'(strobe_end) + 2 * early_strobe, 1);
    endtask

    task automatic wait_strobe(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_strobe && n < 3000);
        check_val(tag, n, exp_n);
    endtask

    initial begin
        int exp_duty;
        int strobe_seen;
        int led_seen;

        bus.en        = 1'b1;
        bus.led_in    = 8'h01;
        bus.max_level = 8'd255;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_led", int'(bus.led_out), 0);
        check_val("rst_strobe", int'(bus.period_strobe), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        wait_strobe("first_strobe", 1024);

        // Fade up: 16, 32, ... 240, 255, then hold
        for (int k = 1; k <= 17; k++) begin
            exp_duty = (16 * k > 255) ? 255 : 16 * k;
            check_period($sformatf("up%0d", k), 4 * exp_duty, 0, int'(exp_duty != 255));
        end

        // Ceiling drop to 100: one period still at 255, then 239 .. 111, 100
        bus.max_level = 8'd100;
        for (int m = 0; m <= 10; m++) begin
            exp_duty = (m == 0) ? 255 : ((255 - 16 * m < 100) ? 100 : 255 - 16 * m);
            check_period($sformatf("down%0d", m), 4 * exp_duty, 0, int'(exp_duty != 100));
        end

        // Glitch on led_in[3] between two fade steps
        fork
            check_period("glitch", 400, 0, 0);
            begin
                repeat (100) @(negedge clk);
                bus.led_in = 8'h09;
                repeat (2) @(negedge clk);
                check_val("glitch_busy", int'(bus.busy), 1);
                repeat (198) @(negedge clk);
                bus.led_in = 8'h01;
            end
        join
        check_period("post_glitch", 400, 0, 0);

        // Enable freeze mid-period
        repeat (300) @(negedge clk);
        check_val("pre_frz_led0", int'(bus.led_out[0]), 1);
        bus.en = 1'b0;
        @(negedge clk);
        check_val("frz_led", int'(bus.led_out), 0);
        strobe_seen = 0;
        led_seen    = 0;
        for (int s = 1; s <= 3000; s++) begin
            @(negedge clk);
            strobe_seen += int'(bus.period_strobe);
            led_seen    += int'(bus.led_out != '0);
            if (s == 1000) bus.led_in = 8'h00;
            if (s == 1002) check_val("frz_busy_on", int'(bus.busy), 1);
            if (s == 1010) bus.led_in = 8'h01;
        end
        check_val("frz_strobe", strobe_seen, 0);
        check_val("frz_led_any", led_seen, 0);
        check_val("frz_busy_off", int'(bus.busy), 0);
        bus.en = 1'b1;
        wait_strobe("resume_strobe", 724);
        check_period("resume", 400, 0, 0);

        // Reset mid-fade
        bus.led_in = 8'hFF;
        check_period("fade_all", 400, 0, 1);
        repeat (20) @(negedge clk);
        check_val("pre_rst_led0", int'(bus.led_out[0]), 1);
        check_val("pre_rst_busy", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_led", int'(bus.led_out), 0);
        check_val("arst_strobe", int'(bus.period_strobe), 0);
        check_val("arst_busy", int'(bus.busy), 0);
        bus.led_in    = 8'h01;
        bus.max_level = 8'd255;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_strobe("rerst_strobe", 1024);
        check_period("rerst_up1", 64, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
Output stage that sits directly downstream of the reconfigurable shift and count modules. It takes their 8 combined LED bits (shift_out on [3:0], count_out on [7:4]) as on/off targets and drives the physical LEDs with PWM dimming. Brightness fades toward each target at a fixed rate, under a global brightness ceiling. This gives smooth LED transitions and keeps the LED pins stable across partial reconfiguration of the upstream modules.

Parameters:
N_LED, 8, number of LED channels
PWM_BITS, 8, width of the PWM counter and duty registers
PRESCALE, 4, clk cycles per PWM count step (>=1)
FADE_PERIODS, 4, PWM periods per fade step (>=1)
STEP, 16, duty change per fade step (1..2^PWM_BITS-1)

Ports:
clk  input  1  system clock (pl_clk)
rst  input  1  asynchronous reset, active-high
en  input  1  run enable; low freezes the block and blanks the LEDs
led_in  input  N_LED  target per LED (1 = on at max_level, 0 = off)
max_level  input  PWM_BITS  brightness ceiling
led_out  output  N_LED  registered PWM drive to the LED pins
period_strobe  output  1  one-clk pulse at each PWM period wrap
busy  output  1  registered; high while any duty differs from its target

Behaviour:
- Reset (async assert, sync release):
  - Cleared: prescaler, pwm_cnt, fade counter, all duty[i], led_out, period_strobe, busy.
  - Outputs go to 0 immediately on rst assertion, with no clock edge needed.
- Prescaler pre:
  - Counts 0..PRESCALE-1 while en=1.
  - tick = (pre==PRESCALE-1); pre wraps to 0 on tick.
- PWM counter pwm_cnt:
  - Increments on tick, modulo 2^PWM_BITS.
  - wrap = tick && pwm_cnt==2^PWM_BITS-1.
  - period_strobe is registered: high for exactly the one clk in which pwm_cnt reads 0 after a wrap.
  - Defaults give a period of 1024 clk.
- Fade counter fcnt:
  - Counts wraps 0..FADE_PERIODS-1.
  - fade_step = wrap && fcnt==FADE_PERIODS-1.
- Targets:
  - target[i] = led_in[i] ? max_level : 0.
  - led_in and max_level are sampled only on the fade_step cycle. Changes between steps have no effect.
- Fade arithmetic, on fade_step, per channel, in PWM_BITS+1 width (no wrap-around):
  - duty<target: duty = min(duty+STEP, target).
  - duty>target: duty = max(duty-STEP, target).
  - Equal: hold.
- Ceiling change: duty never jumps. A duty above a new lower max_level ramps down by STEP per step.
- PWM compare: led_out[i] <= en && (duty[i] > pwm_cnt), one clk latency.
  - duty=0: LED never on.
  - duty=2^PWM_BITS-1: LED on for all but one count per period.
- busy <= OR over i of (duty[i] != target[i]), using current inputs, evaluated every clk.
- en=0:
  - led_out is 0 from the next clk.
  - pre, pwm_cnt, fcnt and duty hold their values; no period_strobe, no fade steps.
  - busy continues to update.
  - en=1 resumes from the held state with no restart.
- Simultaneous rst and anything else: rst wins.
- Reset mid-fade: duty returns to 0, with no residual brightness.

Test Plan:
1. Reset timing: assert rst mid-run → led_out, period_strobe and busy are 0 before the next edge. After release with en=1, the first period_strobe is 1024 clk later, then every 1024 clk.
2. Fade up:
   - Setup: FADE_PERIODS=1, max_level=255, led_in=8'h01 from reset.
   - duty[0] steps 16, 32, … 240, then 255 at step 16.
   - busy drops the clk after duty[0] reaches 255.
   - Per period, led_out[0] high clk count = 4*duty[0].
3. Ceiling drop:
   - Setup: duty[0]=255, max_level set to 100.
   - duty[0] steps 239, 223, … 111, then 100 (10 steps).
   - busy=1 throughout, then 0.
4. Enable freeze:
   - Drop en mid-period → led_out=0 next clk, no period_strobe, and pwm_cnt/duty unchanged after 3000 clk.
   - Raise en → counting resumes from the held pwm_cnt.
5. Duty extremes (duty 0 and 255, over one 1024-clk period):
   - duty=0: led_out low for the whole period.
   - duty=255: led_out high for exactly 1020 clk.
6. Glitch rejection: pulse led_in[3] high for 200 clk entirely between two fade steps → duty[3] stays 0 and led_out[3] never asserts.
